// File: rtl/seq_mult_unit_if.sv
// Request/response bundle for seq_mult_unit: operands and start in, busy/done/product back.
// The master issues requests; the slave is the multiplier.
interface seq_mult_unit_if #(
    parameter int WIDTH = 32
);
    logic               start;
    logic               signed_op;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic               busy;
    logic               done;
    logic [2*WIDTH-1:0] product;

    modport master (
        output start, signed_op, op_a, op_b,
        input  busy, done, product
    );

    modport slave (
        input  start, signed_op, op_a, op_b,
        output busy, done, product
    );
endinterface

// File: rtl/seq_mult_unit.sv
// Radix-2 shift-add multiplier, signed or unsigned per request; optional MULT_EARLY_TERM_EN.
// Latency: done WIDTH clocks after the capture edge (1..WIDTH with MULT_EARLY_TERM_EN).
// Backpressure: start is ignored while busy; accepted in IDLE or in the DONE cycle.
module seq_mult_unit #(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    seq_mult_unit_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state;
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   mplier;
    logic [CNT_W-1:0]   cnt;
    logic               neg;
    logic [2*WIDTH-1:0] prod_q;
    logic               busy_q;
    logic               done_q;

    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [2*WIDTH-1:0] acc_sum;
    logic               last;

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.product = prod_q;

    always_comb begin
        mag_a   = (bus.signed_op && bus.op_a[WIDTH-1]) ? -bus.op_a : bus.op_a;
        mag_b   = (bus.signed_op && bus.op_b[WIDTH-1]) ? -bus.op_b : bus.op_b;
        // mcand is pre-shifted each cycle, so it already carries the iteration weight
        acc_sum = mplier[0] ? (acc + mcand) : acc;
`ifdef MULT_EARLY_TERM_EN
        last    = (cnt == CNT_W'(1)) || (mplier[WIDTH-1:1] == '0);
`else
        last    = (cnt == CNT_W'(1));
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            mcand  <= '0;
            acc    <= '0;
            mplier <= '0;
            cnt    <= '0;
            neg    <= 1'b0;
            prod_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        mcand  <= {{WIDTH{1'b0}}, mag_a};
                        mplier <= mag_b;
                        acc    <= '0;
                        cnt    <= CNT_W'(WIDTH);
                        // a zero operand never yields a negated (-0) result
                        neg    <= bus.signed_op && (bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1])
                                  && (|bus.op_a) && (|bus.op_b);
                        busy_q <= 1'b1;
                        state  <= S_BUSY;
                    end else begin
                        state  <= S_IDLE;
                    end
                end
                S_BUSY: begin
                    acc    <= acc_sum;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt - CNT_W'(1);
                    if (last) begin
                        prod_q <= neg ? -acc_sum : acc_sum;
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= S_DONE;
                    end
                end
                default: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_seq_mult_unit.sv
// Scoreboard bench for seq_mult_unit: directed corner cases plus random requests
// checked against a plain-arithmetic reference model.
module tb_seq_mult_unit;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seq_mult_unit_if #(.WIDTH(W)) bus ();
    seq_mult_unit #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [2*W-1:0] prod;
        int             cyc0;
        int             lat;
    } exp_t;

    exp_t           sb[$];
    int             cyc = 0;
    int             checks = 0;
    int             errors = 0;
    bit             mon_en = 1'b0;
    logic [2*W-1:0] held = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [2*W-1:0] got, input logic [2*W-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    function automatic logic [2*W-1:0] ref_prod(input bit s, input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa;
        longint sb_;
        logic [2*W-1:0] ua;
        logic [2*W-1:0] ub;
        if (s) begin
            sa = $signed(a);
            sb_ = $signed(b);
            return sa * sb_;
        end
        ua = {{W{1'b0}}, a};
        ub = {{W{1'b0}}, b};
        return ua * ub;
    endfunction

    function automatic int ref_lat(input bit s, input logic [W-1:0] b);
`ifdef MULT_EARLY_TERM_EN
        logic [W-1:0] mag;
        mag = (s && b[W-1]) ? -b : b;
        for (int i = W - 1; i >= 0; i--)
            if (mag[i]) return i + 1;
        return 1;
`else
        return W;
`endif
    endfunction

    // Caller is positioned #1 after a rising edge.
    task automatic wait_idle();
        int n = 0;
        while (bus.busy && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (bus.busy) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: busy still %b after %0d cycles, required 0", bus.busy, n);
        end
    endtask

    task automatic issue(input bit s, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        wait_idle();
        bus.start = 1'b1;
        bus.signed_op = s;
        bus.op_a = a;
        bus.op_b = b;
        @(posedge clk); #1;
        e.prod = ref_prod(s, a, b);
        e.cyc0 = cyc;
        e.lat = ref_lat(s, b);
        sb.push_back(e);
        bus.start = 1'b0;
        chk("busy_after_start", {63'd0, bus.busy}, 64'd1);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 6))
            0: return '0;
            1: return '1;
            2: return 32'h8000_0000;
            3: return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.busy && bus.done) begin
                checks++;
                errors++;
                $display("FAIL busy_and_done: busy=%b done=%b, required not both", bus.busy, bus.done);
            end
            if (bus.done) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: done=1 with no request outstanding");
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("product", bus.product, e.prod);
                    chk("latency", 64'(cyc - e.cyc0), 64'(e.lat));
                    held = e.prod;
                end
            end else begin
                chk("product_hold", bus.product, held);
            end
        end
    end

    initial begin
        bus.start = 1'b0;
        bus.signed_op = 1'b0;
        bus.op_a = '0;
        bus.op_b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", {63'd0, bus.busy}, 64'd0);
        chk("reset_done", {63'd0, bus.done}, 64'd0);
        chk("reset_product", bus.product, 64'd0);
        rst = 1'b0;
        mon_en = 1'b1;
        @(posedge clk); #1;

        issue(1'b1, 32'd6, 32'hFFFF_FFF9);
        issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(1'b1, 32'h8000_0000, 32'h8000_0000);
        issue(1'b1, 32'h8000_0000, 32'd1);
        issue(1'b0, 32'd5, 32'd0);
        issue(1'b0, 32'd5, 32'd2);
        issue(1'b1, 32'd0, 32'hFFFF_FFFF);

        // start during BUSY is dropped; start in the DONE cycle is taken
        issue(1'b0, 32'd7, 32'h8000_0009);
        repeat (5) @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.signed_op = 1'b1;
        bus.op_a = 32'd3;
        bus.op_b = 32'd4;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_idle();
        chk("done_cycle_before_b2b", {63'd0, bus.done}, 64'd1);
        issue(1'b0, 32'd3, 32'd4);

        // reset mid-operation abandons it without a done pulse
        issue(1'b1, 32'h0001_2345, 32'h8000_0001);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        held = '0;
        chk("midrst_busy", {63'd0, bus.busy}, 64'd0);
        chk("midrst_done", {63'd0, bus.done}, 64'd0);
        chk("midrst_product", bus.product, 64'd0);
        repeat (40) @(posedge clk);
        #1;

        for (int i = 0; i < 150; i++) begin
            logic [W-1:0] a;
            logic [W-1:0] b;
            bit s;
            a = pick();
            b = pick();
            s = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            issue(s, a, b);
        end

        begin
            int n = 0;
            while (sb.size() != 0 && n < 200) begin
                @(posedge clk); #1;
                n++;
            end
            chk("drain_outstanding", 64'(sb.size()), 64'd0);
        end
        repeat (3) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
